// File: rtl/spi_regbank_pkg.sv
// Shared types for the SPI register bank: frame field positions, register
// address map, FSM states and the error response words.
package spi_regbank_pkg;

  typedef enum logic [2:0] {
    ADDR_CTRL    = 3'd0,
    ADDR_FREQ    = 3'd1,
    ADDR_DUTY_H  = 3'd2,
    ADDR_DUTY_L  = 3'd3,
    ADDR_MON_H   = 3'd4,
    ADDR_MON_L   = 3'd5,
    ADDR_STATUS  = 3'd6,
    ADDR_ERR_CNT = 3'd7
  } addr_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2
  } state_e;

  localparam int FRM_RW_BIT   = 15;
  localparam int FRM_ADDR_MSB = 14;
  localparam int FRM_ADDR_LSB = 12;
  localparam int FRM_PAR_BIT  = 11;
  localparam int FRM_RSVD_BIT = 10;
  localparam int FRM_DATA_MSB = 9;

  localparam logic [15:0] TX_ERR_RO     = 16'hFFFF;
  localparam logic [15:0] TX_ERR_PARITY = 16'hFFFE;

  // Read response: bit15 clear, address echoed, two zero bits, 10-bit value.
  function automatic logic [15:0] read_word(input addr_e a, input logic [9:0] v);
    return {1'b0, a, 2'b00, v};
  endfunction

endpackage

// File: rtl/spi_frame_decode.sv
// Combinational split of a 16-bit SPI frame into fields, plus the optional
// parity check enabled by REGBANK_PARITY_EN.
module spi_frame_decode
  import spi_regbank_pkg::*;
(
  input  logic [15:0] frame_i,
  output logic        is_write_o,
  output addr_e       addr_o,
  output logic [9:0]  data_o,
  output logic        parity_bad_o
);

  logic unused_rsvd;

  assign is_write_o  = frame_i[FRM_RW_BIT];
  assign addr_o      = addr_e'(frame_i[FRM_ADDR_MSB:FRM_ADDR_LSB]);
  assign data_o      = frame_i[FRM_DATA_MSB:0];
  assign unused_rsvd = frame_i[FRM_RSVD_BIT];

`ifdef REGBANK_PARITY_EN
  // Frames must carry an odd number of ones; an even count is rejected.
  assign parity_bad_o = ~(^frame_i);
`else
  logic unused_par;
  assign unused_par   = frame_i[FRM_PAR_BIT];
  assign parity_bad_o = 1'b0;
`endif

endmodule

// File: rtl/spi_regbank.sv
// SPI-facing register bank with shadow/active setpoints committed at PWM
// period start. Optional frame parity checking under REGBANK_PARITY_EN.
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [15:0] rx_frame,
  input  logic        commit_strobe,
  input  logic [9:0]  mon_duty_high,
  input  logic [9:0]  mon_duty_low,
  output logic [15:0] tx_data,
  output logic        tx_load,
  output logic        en_pwm,
  output logic        mode_manual,
  output logic [9:0]  freq_switch,
  output logic [9:0]  man_duty_high,
  output logic [9:0]  man_duty_low,
  output logic        busy
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] base,
                                               input logic [1:0] inc);
    logic [ERR_W:0] sum;
    sum = {1'b0, base} + {{(ERR_W-1){1'b0}}, inc};
    return sum[ERR_W] ? ERR_MAX : sum[ERR_W-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [15:0]      frame_q;
  logic             sh_en_q, sh_en_d, sh_mode_q, sh_mode_d;
  logic [9:0]       sh_freq_q, sh_freq_d, sh_dh_q, sh_dh_d, sh_dl_q, sh_dl_d;
  logic             en_q, en_d, mode_q, mode_d;
  logic [9:0]       freq_q, freq_d, dh_q, dh_d, dl_q, dl_d;
  logic             pending_q, pending_d, overrun_q, overrun_d, par_err_q, par_err_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [15:0]      tx_data_q, tx_data_d;
  logic             tx_load_q, tx_load_d;

  logic       dec_write, dec_par_bad;
  addr_e      dec_addr;
  logic [9:0] dec_data, rd_val;
  logic       accept, overrun_evt, par_evt, wr_exec, ro_err, wr_shadow;
  logic       err_clr, safety_off, rd_status;
  logic [1:0] err_events;

  spi_frame_decode u_dec (
    .frame_i      (frame_q),
    .is_write_o   (dec_write),
    .addr_o       (dec_addr),
    .data_o       (dec_data),
    .parity_bad_o (dec_par_bad)
  );

  assign accept      = rx_valid && (state_q == ST_IDLE);
  assign overrun_evt = rx_valid && (state_q != ST_IDLE);
  assign par_evt     = (state_q == ST_DECODE) && dec_par_bad;
  assign wr_exec     = (state_q == ST_EXEC) && dec_write;
  assign ro_err      = wr_exec && (dec_addr inside {ADDR_MON_H, ADDR_MON_L, ADDR_STATUS});
  assign wr_shadow   = wr_exec && (dec_addr inside {ADDR_CTRL, ADDR_FREQ, ADDR_DUTY_H, ADDR_DUTY_L});
  assign err_clr     = wr_exec && (dec_addr == ADDR_ERR_CNT);
  // Disabling the PWM bypasses the commit point and acts in the EXEC cycle itself.
  assign safety_off  = wr_exec && (dec_addr == ADDR_CTRL) && !dec_data[0];
  assign rd_status   = (state_q == ST_EXEC) && !dec_write && (dec_addr == ADDR_STATUS);
  assign err_events  = {1'b0, overrun_evt} + {1'b0, ro_err} + {1'b0, par_evt};

  always_comb begin
    rd_val = '0;
    case (dec_addr)
      ADDR_CTRL:    rd_val = {8'b0, sh_mode_q, sh_en_q};
      ADDR_FREQ:    rd_val = sh_freq_q;
      ADDR_DUTY_H:  rd_val = sh_dh_q;
      ADDR_DUTY_L:  rd_val = sh_dl_q;
      ADDR_MON_H:   rd_val = mon_duty_high;
      ADDR_MON_L:   rd_val = mon_duty_low;
      ADDR_STATUS:  rd_val = {7'b0, pending_q, overrun_q | overrun_evt, par_err_q};
      ADDR_ERR_CNT: rd_val = 10'(err_q);
      default:      rd_val = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sh_en_d   = sh_en_q;   sh_mode_d = sh_mode_q;
    sh_freq_d = sh_freq_q; sh_dh_d   = sh_dh_q;   sh_dl_d = sh_dl_q;
    en_d      = en_q;      mode_d    = mode_q;
    freq_d    = freq_q;    dh_d      = dh_q;      dl_d    = dl_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    par_err_d = par_err_q;
    err_d     = sat_add(err_clr ? '0 : err_q, err_events);
    tx_data_d = tx_data_q;
    tx_load_d = 1'b0;

    case (state_q)
      ST_IDLE:   if (rx_valid) state_d = ST_DECODE;
      ST_DECODE: begin
        tx_load_d = 1'b1;
        if (dec_par_bad) begin
          state_d   = ST_IDLE;
          tx_data_d = TX_ERR_PARITY;
        end else begin
          state_d = ST_EXEC;
          if (!dec_write)   tx_data_d = read_word(dec_addr, rd_val);
          else if (ro_err || (dec_addr inside {ADDR_MON_H, ADDR_MON_L, ADDR_STATUS}))
                            tx_data_d = TX_ERR_RO;
          else              tx_data_d = frame_q;
        end
      end
      ST_EXEC:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Commit uses the shadow as it stood before any same-cycle write.
    if (commit_strobe && pending_q) begin
      en_d      = sh_en_q;   mode_d = sh_mode_q;
      freq_d    = sh_freq_q; dh_d   = sh_dh_q;   dl_d = sh_dl_q;
      pending_d = 1'b0;
    end
    if (wr_shadow) begin
      pending_d = 1'b1;
      case (dec_addr)
        ADDR_CTRL:   begin sh_en_d = dec_data[0]; sh_mode_d = dec_data[1]; end
        ADDR_FREQ:   sh_freq_d = dec_data;
        ADDR_DUTY_H: sh_dh_d   = dec_data;
        default:     sh_dl_d   = dec_data;
      endcase
    end
    if (safety_off) en_d = 1'b0;

    if (rd_status) begin
      overrun_d = 1'b0;
      par_err_d = 1'b0;
    end
    if (overrun_evt) overrun_d = 1'b1;
    if (par_evt)     par_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      sh_en_q   <= 1'b0; sh_mode_q <= 1'b0;
      sh_freq_q <= '0;   sh_dh_q   <= '0;   sh_dl_q <= '0;
      en_q      <= 1'b0; mode_q    <= 1'b0;
      freq_q    <= '0;   dh_q      <= '0;   dl_q    <= '0;
      pending_q <= 1'b0; overrun_q <= 1'b0; par_err_q <= 1'b0;
      err_q     <= '0;
      tx_data_q <= '0;   tx_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_en_q   <= sh_en_d;   sh_mode_q <= sh_mode_d;
      sh_freq_q <= sh_freq_d; sh_dh_q   <= sh_dh_d;   sh_dl_q <= sh_dl_d;
      en_q      <= en_d;      mode_q    <= mode_d;
      freq_q    <= freq_d;    dh_q      <= dh_d;      dl_q    <= dl_d;
      pending_q <= pending_d; overrun_q <= overrun_d; par_err_q <= par_err_d;
      err_q     <= err_d;
      tx_data_q <= tx_data_d; tx_load_q <= tx_load_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) frame_q <= rx_frame;
  end

  assign tx_data       = tx_data_q;
  assign tx_load       = tx_load_q;
  assign en_pwm        = en_q && !safety_off;
  assign mode_manual   = mode_q;
  assign freq_switch   = freq_q;
  assign man_duty_high = dh_q;
  assign man_duty_low  = dl_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_regbank.sv
// Self-checking bench for spi_regbank (default build, parity feature off).
`timescale 1ns/1ps
module tb_spi_regbank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_frame = '0;
  logic        commit_strobe = 1'b0;
  logic [9:0]  mon_duty_high = '0;
  logic [9:0]  mon_duty_low = '0;
  logic [15:0] tx_data;
  logic        tx_load;
  logic        en_pwm, mode_manual, busy;
  logic [9:0]  freq_switch, man_duty_high, man_duty_low;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  spi_regbank #(.ERR_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_frame      (rx_frame),
    .commit_strobe (commit_strobe),
    .mon_duty_high (mon_duty_high),
    .mon_duty_low  (mon_duty_low),
    .tx_data       (tx_data),
    .tx_load       (tx_load),
    .en_pwm        (en_pwm),
    .mode_manual   (mode_manual),
    .freq_switch   (freq_switch),
    .man_duty_high (man_duty_high),
    .man_duty_low  (man_duty_low),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every tx_load must match the oldest expected response and cycle.
  always @(negedge clk) begin
    if (tx_load) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got tx_data=%h at cycle %0d, none expected", tx_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (tx_data !== e.data || cyc !== e.cyc) begin
          errors++;
          $display("FAIL tx_response: got %h at cycle %0d, expected %h at cycle %0d",
                   tx_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [15:0] f, input logic [15:0] exp);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_frame = f;
    sb.push_back('{data: exp, cyc: cyc + 2});
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_frame = '0;
    repeat (3) @(posedge clk);
  endtask

  task automatic pulse_commit();
    @(posedge clk); #1;
    commit_strobe = 1'b1;
    @(posedge clk); #1;
    commit_strobe = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({tx_data, tx_load, busy, en_pwm, mode_manual} !== 20'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got tx=%h load=%b busy=%b en=%b mode=%b, expected all 0",
               tx_data, tx_load, busy, en_pwm, mode_manual);
    end
    checks++;
    if ({freq_switch, man_duty_high, man_duty_low} !== 30'h0) begin
      errors++;
      $display("FAIL reset_setpoints: got %h %h %h, expected 0", freq_switch, man_duty_high, man_duty_low);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_write_commit();
    send_frame(16'h912C, 16'h912C);
    @(posedge clk); #1;
    commit_strobe = 1'b1;
    checks++;
    if (freq_switch !== 10'd0) begin
      errors++;
      $display("FAIL freq_before_commit: got %0d, expected 0", freq_switch);
    end
    @(posedge clk); #1;
    commit_strobe = 1'b0;
    checks++;
    if (freq_switch !== 10'd300) begin
      errors++;
      $display("FAIL freq_after_commit: got %0d, expected 300", freq_switch);
    end
    send_frame(16'h1000, 16'h112C);
  endtask

  task automatic test_en_safety();
    send_frame(16'h8001, 16'h8001);
    pulse_commit();
    checks++;
    if (en_pwm !== 1'b1) begin
      errors++;
      $display("FAIL en_after_commit: got %b, expected 1", en_pwm);
    end
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_frame = 16'h8000;
    sb.push_back('{data: 16'h8000, cyc: cyc + 2});
    @(posedge clk); #1;
    rx_valid = 1'b0;
    checks++;
    if (en_pwm !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL en_in_decode: got en=%b busy=%b, expected en=1 busy=1", en_pwm, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (en_pwm !== 1'b0) begin
      errors++;
      $display("FAIL en_safety_exec: got %b, expected 0", en_pwm);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (en_pwm !== 1'b0) begin
      errors++;
      $display("FAIL en_stays_off: got %b, expected 0", en_pwm);
    end
    send_frame(16'h8002, 16'h8002);
    pulse_commit();
    checks++;
    if (mode_manual !== 1'b1 || en_pwm !== 1'b0) begin
      errors++;
      $display("FAIL ctrl_mode_commit: got mode=%b en=%b, expected mode=1 en=0", mode_manual, en_pwm);
    end
    send_frame(16'h0000, 16'h0002);
  endtask

  task automatic test_read_mon();
    mon_duty_high = 10'h155;
    mon_duty_low  = 10'h2AA;
    send_frame(16'h4000, 16'h4155);
    send_frame(16'h5000, 16'h52AA);
  endtask

  task automatic test_ro_write_errcnt();
    send_frame(16'hC123, 16'hFFFF);
    send_frame(16'hD000, 16'hFFFF);
    send_frame(16'hE000, 16'hFFFF);
    send_frame(16'h7000, 16'h7003);
    send_frame(16'hF000, 16'hF000);
    send_frame(16'h7000, 16'h7000);
    send_frame(16'h6000, 16'h6000);
  endtask

  task automatic test_overrun();
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_frame = 16'h0000;
    sb.push_back('{data: 16'h0002, cyc: cyc + 2});
    @(posedge clk); #1;
    rx_frame = 16'h9001;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_frame = '0;
    repeat (3) @(posedge clk);
    send_frame(16'h6000, 16'h6002);
    send_frame(16'h7000, 16'h7001);
    send_frame(16'h6000, 16'h6000);
    send_frame(16'h1000, 16'h112C);
  endtask

  task automatic test_commit_coincident();
    send_frame(16'hA005, 16'hA005);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_frame = 16'hA007;
    sb.push_back('{data: 16'hA007, cyc: cyc + 2});
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    commit_strobe = 1'b1;
    @(posedge clk); #1;
    commit_strobe = 1'b0;
    checks++;
    if (man_duty_high !== 10'd5) begin
      errors++;
      $display("FAIL coincident_commit: got %0d, expected 5", man_duty_high);
    end
    repeat (2) @(posedge clk);
    send_frame(16'h6000, 16'h6004);
    pulse_commit();
    checks++;
    if (man_duty_high !== 10'd7) begin
      errors++;
      $display("FAIL later_commit: got %0d, expected 7", man_duty_high);
    end
    send_frame(16'hB0AA, 16'hB0AA);
    pulse_commit();
    checks++;
    if (man_duty_low !== 10'h0AA) begin
      errors++;
      $display("FAIL duty_low_commit: got %h, expected 0aa", man_duty_low);
    end
    send_frame(16'h6000, 16'h6000);
  endtask

  task automatic test_err_saturate();
    send_frame(16'hF000, 16'hF000);
    for (int i = 0; i < 260; i++) send_frame(16'hC000, 16'hFFFF);
    send_frame(16'h7000, 16'h70FF);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_frame = 16'hF000;
    sb.push_back('{data: 16'hF000, cyc: cyc + 2});
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_frame = 16'h0000;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    send_frame(16'h7000, 16'h7001);
    send_frame(16'h6000, 16'h6002);
  endtask

  task automatic test_parity_ignored();
    send_frame(16'h8001, 16'h8001);
    send_frame(16'h0000, 16'h0001);
    send_frame(16'h6000, 16'h6004);
    pulse_commit();
    checks++;
    if (en_pwm !== 1'b1) begin
      errors++;
      $display("FAIL en_reenable: got %b, expected 1", en_pwm);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_frame = 16'hB155;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_decode: got %b, expected 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, tx_load, en_pwm, mode_manual, tx_data, freq_switch, man_duty_high, man_duty_low} !== 50'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b load=%b en=%b mode=%b tx=%h f=%h dh=%h dl=%h, expected 0",
               busy, tx_load, en_pwm, mode_manual, tx_data, freq_switch, man_duty_high, man_duty_low);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    send_frame(16'h3000, 16'h3000);
    send_frame(16'h6000, 16'h6000);
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_en_safety();
    test_read_mon();
    test_ro_write_errcnt();
    test_overrun();
    test_commit_coincident();
    test_err_saturate();
    test_parity_ignored();
    test_reset_mid();
    repeat (3) @(posedge clk); #1;
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sb_drained: got %0d pending responses, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
